// File: rtl/i2c_slave_front_end.sv
// I2C slave front end: synchronizes SCL/SDA, detects START/STOP, receives the
// address byte, drives the address ACK and flags an addressed write to the data-in stage.
module i2c_slave_front_end #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       FPGA_clk,
    input  logic       rst,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SCL,
    output logic       SCL_prev,
    output logic       SDA,
    output logic       SDA_prev,
    output logic       sda_drive_low,
    output logic       enable,
    output logic       start_det,
    output logic       stop_det,
    output logic       addr_match,
    output logic       rw_bit,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK    = 3'd2,
        ACTIVE = 3'd3,
        IGNORE = 3'd4
    } state_t;

    state_t      state, state_n;
    logic        scl_meta, sda_meta;
    logic [7:0]  shift, shift_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic        ack_rise, ack_rise_n;
    logic        match_n, rw_n, drive_n, enable_n;
    logic        rise, fall, start_cond, stop_cond;

    // Reset to an idle (high) bus so releasing reset can never look like a START.
    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 1'b1;
            sda_meta <= 1'b1;
            SCL      <= 1'b1;
            SDA      <= 1'b1;
            SCL_prev <= 1'b1;
            SDA_prev <= 1'b1;
        end else begin
            scl_meta <= SCL_in;
            sda_meta <= SDA_in;
            SCL      <= scl_meta;
            SDA      <= sda_meta;
            SCL_prev <= SCL;
            SDA_prev <= SDA;
        end
    end

    assign rise       = SCL & ~SCL_prev;
    assign fall       = ~SCL & SCL_prev;
    assign start_cond = SCL & SCL_prev & SDA_prev & ~SDA;
    assign stop_cond  = SCL & SCL_prev & ~SDA_prev & SDA;
    assign fsm_state  = state;

    always_ff @(posedge FPGA_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shift         <= 8'd0;
            bit_cnt       <= 4'd0;
            ack_rise      <= 1'b0;
            addr_match    <= 1'b0;
            rw_bit        <= 1'b0;
            sda_drive_low <= 1'b0;
            enable        <= 1'b0;
            start_det     <= 1'b0;
            stop_det      <= 1'b0;
        end else begin
            state         <= state_n;
            shift         <= shift_n;
            bit_cnt       <= bit_cnt_n;
            ack_rise      <= ack_rise_n;
            addr_match    <= match_n;
            rw_bit        <= rw_n;
            sda_drive_low <= drive_n;
            enable        <= enable_n;
            start_det     <= start_cond;
            stop_det      <= stop_cond;
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        ack_rise_n = ack_rise;
        match_n    = addr_match;
        rw_n       = rw_bit;
        drive_n    = sda_drive_low;
        // Based on the current state so enable trails ACTIVE entry by one cycle.
        enable_n   = (state == ACTIVE) && !rw_bit && !start_cond && !stop_cond;

        if (start_cond) begin
            state_n   = ADDR;
            shift_n   = 8'd0;
            bit_cnt_n = 4'd0;
            match_n   = 1'b0;
            drive_n   = 1'b0;
        end else if (stop_cond) begin
            state_n = IDLE;
            match_n = 1'b0;
            drive_n = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (rise && (bit_cnt < 4'd8)) begin
                        shift_n   = {shift[6:0], SDA};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw_n    = SDA;
                            match_n = (shift[6:0] == SLAVE_ADDR);
                        end
                    end
                    if (fall && (bit_cnt == 4'd8)) begin
                        ack_rise_n = 1'b0;
                        if (addr_match) begin
                            state_n = ACK;
                            drive_n = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ACK: begin
                    // Hold the ACK through the 9th high phase; release on the fall after it.
                    if (rise) begin
                        ack_rise_n = 1'b1;
                    end
                    if (fall && ack_rise) begin
                        drive_n = 1'b0;
                        state_n = ACTIVE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_front_end.sv
// Bench for i2c_slave_front_end: bit-banged I2C master with a wired-AND SDA line,
// an event scoreboard for start/stop pulses and inline checks per scenario.
module tb_i2c_slave_front_end;

    localparam int W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_bus;
    logic scl_s, scl_p, sda_s, sda_p, drive, en, sdet, pdet, match, rw;
    logic [2:0] st;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic m_match, m_ack, m_en, last_start, last_stop;
    logic [W-1:0] obs, expv;

    assign sda_bus = sda_m & ~drive;

    always #5 clk = ~clk;

    i2c_slave_front_end #(.SLAVE_ADDR(7'h42)) dut (
        .FPGA_clk(clk), .rst(rst), .SCL_in(scl_m), .SDA_in(sda_bus),
        .SCL(scl_s), .SCL_prev(scl_p), .SDA(sda_s), .SDA_prev(sda_p),
        .sda_drive_low(drive), .enable(en), .start_det(sdet), .stop_det(pdet),
        .addr_match(match), .rw_bit(rw), .fsm_state(st)
    );

    // Event record: {stop, start, match seen, ack seen, enable seen} since the previous event.
    always @(negedge clk) begin
        if (rst) begin
            m_match = 1'b0; m_ack = 1'b0; m_en = 1'b0;
            last_start = 1'b0; last_stop = 1'b0;
        end else begin
            m_match = m_match | match;
            m_ack   = m_ack | drive;
            m_en    = m_en | en;
            if (sdet) begin
                n_cmp++;
                if (last_start !== 1'b0) begin
                    n_bad++; $display("FAIL start_pulse_width got=2+ cycles exp=1");
                end
            end
            if (pdet) begin
                n_cmp++;
                if (last_stop !== 1'b0) begin
                    n_bad++; $display("FAIL stop_pulse_width got=2+ cycles exp=1");
                end
            end
            if (sdet || pdet) begin
                obs = {pdet, sdet, m_match, m_ack, m_en};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL sb_unexpected_event got=%b exp=none", obs);
                end else begin
                    expv = exp_q.pop_front();
                    if (obs !== expv) begin
                        n_bad++; $display("FAIL sb_event got=%b exp=%b", obs, expv);
                    end
                end
                m_match = 1'b0; m_ack = 1'b0; m_en = 1'b0;
            end
            last_start = sdet;
            last_stop  = pdet;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        sda_m = 1'b0; wait_clk(20);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        sda_m = 1'b1; wait_clk(20);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            wait_clk(10); sda_m = v[7-i];
            wait_clk(10); scl_m = 1'b1;
            wait_clk(20); scl_m = 1'b0;
        end
    endtask

    task automatic ack_clock(output logic drv_hi);
        wait_clk(10); sda_m = 1'b1;
        wait_clk(10); scl_m = 1'b1;
        wait_clk(10); @(negedge clk) drv_hi = drive;
        wait_clk(10); scl_m = 1'b0;
    endtask

    task automatic test_reset();
        wait_clk(5); @(negedge clk);
        n_cmp++;
        if ({scl_s, scl_p, sda_s, sda_p} !== 4'b1111) begin
            n_bad++; $display("FAIL rst_sync got=%b exp=1111", {scl_s, scl_p, sda_s, sda_p});
        end
        n_cmp++;
        if ({drive, en, sdet, pdet, match, rw, st} !== 9'd0) begin
            n_bad++; $display("FAIL rst_outputs got=%b exp=0", {drive, en, sdet, pdet, match, rw, st});
        end
        @(posedge clk); #2 rst = 1'b0;
        wait_clk(30); @(negedge clk);
        n_cmp++;
        if (st !== 3'd0) begin
            n_bad++; $display("FAIL rst_idle got=%0d exp=0", st);
        end
    endtask

    task automatic test_write();
        logic d;
        exp_q.push_back(5'b01_000);
        i2c_start(); send_bits(8'h84, 8);
        wait_clk(8); @(negedge clk);
        n_cmp++;
        if ({match, rw, drive, st} !== {1'b1, 1'b0, 1'b1, 3'd2}) begin
            n_bad++; $display("FAIL wr_addr got=%b exp=%b", {match, rw, drive, st}, {1'b1, 1'b0, 1'b1, 3'd2});
        end
        ack_clock(d);
        n_cmp++;
        if (d !== 1'b1) begin
            n_bad++; $display("FAIL wr_ack_high got=%b exp=1", d);
        end
        wait_clk(6); @(negedge clk);
        n_cmp++;
        if ({en, drive, st} !== {1'b1, 1'b0, 3'd3}) begin
            n_bad++; $display("FAIL wr_active got=%b exp=%b", {en, drive, st}, {1'b1, 1'b0, 3'd3});
        end
        exp_q.push_back(5'b10_111);
        i2c_stop(); @(negedge clk);
        n_cmp++;
        if ({en, st} !== {1'b0, 3'd0}) begin
            n_bad++; $display("FAIL wr_stop got=%b exp=%b", {en, st}, {1'b0, 3'd0});
        end
    endtask

    task automatic test_no_match();
        logic d;
        exp_q.push_back(5'b01_000);
        i2c_start(); send_bits(8'h86, 8);
        wait_clk(8); @(negedge clk);
        n_cmp++;
        if ({match, drive, st} !== {1'b0, 1'b0, 3'd4}) begin
            n_bad++; $display("FAIL nm_addr got=%b exp=%b", {match, drive, st}, {1'b0, 1'b0, 3'd4});
        end
        ack_clock(d);
        n_cmp++;
        if (d !== 1'b0) begin
            n_bad++; $display("FAIL nm_ack got=%b exp=0", d);
        end
        wait_clk(6); @(negedge clk);
        n_cmp++;
        if (en !== 1'b0) begin
            n_bad++; $display("FAIL nm_enable got=%b exp=0", en);
        end
        exp_q.push_back(5'b10_000);
        i2c_stop(); @(negedge clk);
        n_cmp++;
        if (st !== 3'd0) begin
            n_bad++; $display("FAIL nm_stop got=%0d exp=0", st);
        end
    endtask

    task automatic test_read();
        logic d;
        exp_q.push_back(5'b01_000);
        i2c_start(); send_bits(8'h85, 8);
        wait_clk(8); @(negedge clk);
        n_cmp++;
        if ({match, rw, drive, st} !== {1'b1, 1'b1, 1'b1, 3'd2}) begin
            n_bad++; $display("FAIL rd_addr got=%b exp=%b", {match, rw, drive, st}, {1'b1, 1'b1, 1'b1, 3'd2});
        end
        ack_clock(d);
        n_cmp++;
        if (d !== 1'b1) begin
            n_bad++; $display("FAIL rd_ack got=%b exp=1", d);
        end
        wait_clk(6); @(negedge clk);
        n_cmp++;
        if ({en, st} !== {1'b0, 3'd3}) begin
            n_bad++; $display("FAIL rd_active got=%b exp=%b", {en, st}, {1'b0, 3'd3});
        end
        exp_q.push_back(5'b10_110);
        i2c_stop();
    endtask

    task automatic test_back_to_back();
        logic d;
        bit found;
        exp_q.push_back(5'b01_000);
        i2c_start(); send_bits(8'h84, 8);
        wait_clk(8); ack_clock(d);
        wait_clk(6); @(negedge clk);
        n_cmp++;
        if (en !== 1'b1) begin
            n_bad++; $display("FAIL b2b_enable1 got=%b exp=1", en);
        end
        exp_q.push_back(5'b01_111);
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(20);
        sda_m = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            @(negedge clk);
            if (sdet) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL b2b_restart got=none exp=start_det");
        end
        n_cmp++;
        if (en !== 1'b0) begin
            n_bad++; $display("FAIL b2b_en_at_start got=%b exp=0", en);
        end
        @(negedge clk);
        n_cmp++;
        if (en !== 1'b0) begin
            n_bad++; $display("FAIL b2b_en_after_start got=%b exp=0", en);
        end
        wait_clk(15); scl_m = 1'b0;
        send_bits(8'h84, 8);
        wait_clk(8); ack_clock(d);
        n_cmp++;
        if (d !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ack2 got=%b exp=1", d);
        end
        wait_clk(6); @(negedge clk);
        n_cmp++;
        if (en !== 1'b1) begin
            n_bad++; $display("FAIL b2b_enable2 got=%b exp=1", en);
        end
        exp_q.push_back(5'b10_111);
        i2c_stop();
    endtask

    task automatic test_abort();
        exp_q.push_back(5'b01_000);
        i2c_start(); send_bits(8'hA0, 4);
        exp_q.push_back(5'b10_000);
        i2c_stop(); @(negedge clk);
        n_cmp++;
        if ({st, match, drive} !== {3'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL abort got=%b exp=%b", {st, match, drive}, {3'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_in_ack();
        exp_q.push_back(5'b01_000);
        i2c_start(); send_bits(8'h84, 8);
        wait_clk(18); sda_m = 1'b1;
        wait_clk(10); scl_m = 1'b1;
        wait_clk(10); @(negedge clk);
        n_cmp++;
        if (drive !== 1'b1) begin
            n_bad++; $display("FAIL rack_pre got=%b exp=1", drive);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({drive, en} !== 2'b00) begin
            n_bad++; $display("FAIL rack_async got=%b exp=00", {drive, en});
        end
        wait_clk(3); @(negedge clk);
        n_cmp++;
        if ({scl_s, sda_s} !== 2'b11) begin
            n_bad++; $display("FAIL rack_sync got=%b exp=11", {scl_s, sda_s});
        end
        @(posedge clk); #2 rst = 1'b0;
        wait_clk(30); @(negedge clk);
        n_cmp++;
        if ({st, drive} !== {3'd0, 1'b0}) begin
            n_bad++; $display("FAIL rack_after got=%b exp=%b", {st, drive}, {3'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_no_match();
        test_read();
        test_back_to_back();
        test_abort();
        test_reset_in_ack();
        wait_clk(20);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL sb_pending got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
